// File: rtl/pipeline_control_if.sv
// pipeline_control_if
// Purpose: bundles the handshake and control signals between the datapath
//   (hazard unit, caches, branch/halt detection) and pipeline_control.
//   This covers the stall/flush requests coming in and the enable/flush
//   controls and performance counters going out.
// Modports:
//   master - datapath side: drives the hazard/cache/branch/halt inputs and
//            observes the enables, flushes, halt and counters.
//   slave  - the controller: consumes the inputs and drives the outputs.
// Parameter:
//   CNT_W  - width of each performance counter. It must match the
//            controller's CNT_W.
interface pipeline_control_if #(
  parameter int CNT_W = 32
);
  logic             hazard_dec;
  logic             hazard_ex;
  logic             ihit;
  logic             dmem_req_mem;
  logic             dhit;
  logic             branch_ex;
  logic             halt_mem;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard_dec, hazard_ex, ihit, dmem_req_mem, dhit, branch_ex, halt_mem,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard_dec, hazard_ex, ihit, dmem_req_mem, dhit, branch_ex, halt_mem,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control
// Purpose: stall/flush controller for the five-stage pipeline. Each cycle it
//   combines the hazard unit flags, the cache handshakes, a taken branch in
//   EX and a halt in MEM. From these it produces the PC enable and the
//   enable/flush pair of each pipeline latch. It also sequences the halt
//   drain and keeps saturating performance counters.
// Ports:
//   CLK - system clock, rising edge
//   RST - synchronous active-high reset
//   bus - pipeline_control_if slave modport:
//         in  : hazard_dec, hazard_ex, ihit, dmem_req_mem, dhit,
//               branch_ex, halt_mem
//         out : pc_en, {ifid,idex,exmem,memwb}_en,
//               {ifid,idex,exmem,memwb}_flush, halt,
//               cycle_cnt, stall_cnt, flush_cnt (CNT_W bits each)
module pipeline_control #(
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  pipeline_control_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mstall;
  logic pc_en;
  logic ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic halt;
  logic cycle_inc, stall_inc, flush_inc;

  // A memory op in MEM that has not completed freezes the whole pipe.
  assign mstall = bus.dmem_req_mem & ~bus.dhit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    // Saturate at all-ones rather than wrapping.
    if (inc && !(&v)) return v + CNT_ONE;
    return v;
  endfunction

  // Next-state and output decode. DWAIT behaves like RUN. It only exists to
  // record that the pipe is waiting on the data cache, so both share the same
  // priority list, and the first cycle without mstall falls back to RUN.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halt        = 1'b0;
    cycle_inc   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (RST) begin
      state_d     = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN, DWAIT: begin
          cycle_inc = 1'b1;
          state_d   = RUN;
          if (mstall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = DWAIT;
          end else if (bus.halt_mem) begin
            // Let the halt retire into WB and squash everything younger.
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = DRAIN;
          end else if (bus.hazard_ex) begin
            // Any branch seen now is dropped; it re-resolves once EX is free.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
          end else if (bus.branch_ex) begin
            // PC takes the target even on an ifetch miss; the flush hides the
            // stale fetch.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (bus.hazard_dec) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (!bus.ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
          stall_inc = ~pc_en;
        end
        DRAIN: begin
          cycle_inc   = 1'b1;
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_en    = 1'b0;
          memwb_flush = 1'b1;
          state_d     = HALTED;
        end
        HALTED: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          halt     = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cycle_cnt_d = sat_inc(cycle_cnt_q, cycle_inc);
    stall_cnt_d = sat_inc(stall_cnt_q, stall_inc);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_inc);
  end

  // State and counter registers; reset returns to RUN from any state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halt        = halt;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control
// Purpose: self-checking bench for pipeline_control. Two controllers are
//   driven with identical stimulus: one with 32-bit counters and one with
//   4-bit counters, so that counter saturation can be observed. Outputs are
//   compared against fixed vectors, hand-written sequences and a reference
//   model of the controller's rules.
module tb_pipeline_control;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  pipeline_control_if #(.CNT_W(32)) bus_big ();
  pipeline_control_if #(.CNT_W(4))  bus_small ();

  pipeline_control #(.CNT_W(32)) dut_big (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_big)
  );

  pipeline_control #(.CNT_W(4)) dut_small (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_small)
  );

  // Output bundle order: {pc_en, ifid/idex/exmem/memwb en, same flushes, halt}
  logic [9:0] out_big, out_small;
  assign out_big = {bus_big.pc_en, bus_big.ifid_en, bus_big.idex_en,
                    bus_big.exmem_en, bus_big.memwb_en, bus_big.ifid_flush,
                    bus_big.idex_flush, bus_big.exmem_flush,
                    bus_big.memwb_flush, bus_big.halt};
  assign out_small = {bus_small.pc_en, bus_small.ifid_en, bus_small.idex_en,
                      bus_small.exmem_en, bus_small.memwb_en,
                      bus_small.ifid_flush, bus_small.idex_flush,
                      bus_small.exmem_flush, bus_small.memwb_flush,
                      bus_small.halt};

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: phase 0 = running (including waiting on dcache),
  // 1 = draining, 2 = halted. Counters are kept unbounded and clipped on
  // compare.
  int         m_phase = 0;
  longint     m_cyc   = 0;
  longint     m_stall = 0;
  longint     m_flush = 0;
  int         m_rule;
  logic [9:0] m_exp;

  typedef struct {
    logic [6:0] in;   // {hazard_dec, hazard_ex, ihit, dmem_req_mem, dhit, branch_ex, halt_mem}
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [63:0] satv(input longint raw, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  // Rule numbers: 0 mem stall, 1 halt, 2 hazard_ex, 3 branch,
  // 4 hazard_dec, 5 ifetch miss, 6 advance, -1 not running.
  function automatic logic [9:0] modelOut(input int phase, input logic rst,
                                          input logic [6:0] v, output int rule);
    rule = -1;
    if (rst)         return 10'b0_0000_1111_0;
    if (phase == 2)  return 10'b0_0000_0000_1;
    if (phase == 1)  return 10'b0_0000_0001_0;
    if (v[3] && !v[2]) begin rule = 0; return 10'b0_0000_0000_0; end
    if (v[0])          begin rule = 1; return 10'b0_1111_1110_0; end
    if (v[5])          begin rule = 2; return 10'b0_0011_0010_0; end
    if (v[1])          begin rule = 3; return 10'b1_1111_1100_0; end
    if (v[6])          begin rule = 4; return 10'b0_0111_0100_0; end
    if (!v[4])         begin rule = 5; return 10'b0_1111_1000_0; end
    rule = 6;
    return 10'b1_1111_0000_0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic driveInputs(input logic rst, input logic [6:0] v);
    RST                    = rst;
    bus_big.hazard_dec     = v[6];
    bus_big.hazard_ex      = v[5];
    bus_big.ihit           = v[4];
    bus_big.dmem_req_mem   = v[3];
    bus_big.dhit           = v[2];
    bus_big.branch_ex      = v[1];
    bus_big.halt_mem       = v[0];
    bus_small.hazard_dec   = v[6];
    bus_small.hazard_ex    = v[5];
    bus_small.ihit         = v[4];
    bus_small.dmem_req_mem = v[3];
    bus_small.dhit         = v[2];
    bus_small.branch_ex    = v[1];
    bus_small.halt_mem     = v[0];
  endtask

  // One clock cycle: drive, check at the falling edge, advance model at the
  // rising edge, then return 1 time unit after that edge.
  task automatic applyStimulus(input logic rst, input logic [6:0] v,
                               input bit chk_tab, input logic [9:0] tab_exp);
    driveInputs(rst, v);
    m_exp = modelOut(m_phase, rst, v, m_rule);
    @(negedge CLK);
    checkOutput("outputs", {54'd0, out_big}, {54'd0, m_exp});
    checkOutput("outputs_w4", {54'd0, out_small}, {54'd0, m_exp});
    checkOutput("cycle_cnt", 64'(bus_big.cycle_cnt), satv(m_cyc, 32));
    checkOutput("stall_cnt", 64'(bus_big.stall_cnt), satv(m_stall, 32));
    checkOutput("flush_cnt", 64'(bus_big.flush_cnt), satv(m_flush, 32));
    checkOutput("cycle_cnt_w4", 64'(bus_small.cycle_cnt), satv(m_cyc, 4));
    checkOutput("stall_cnt_w4", 64'(bus_small.stall_cnt), satv(m_stall, 4));
    checkOutput("flush_cnt_w4", 64'(bus_small.flush_cnt), satv(m_flush, 4));
    if (chk_tab) checkOutput("vector", {54'd0, out_big}, {54'd0, tab_exp});
    @(posedge CLK);
    if (rst) begin
      m_phase = 0;
      m_cyc   = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (m_phase != 2) m_cyc++;
      if (m_phase == 0 && !m_exp[9]) m_stall++;
      if (m_rule == 3) m_flush++;
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 0 && m_rule == 1) m_phase = 1;
    end
    #1;
  endtask

  task automatic step(input logic rst, input logic [6:0] v);
    applyStimulus(rst, v, 1'b0, 10'd0);
  endtask

  function automatic logic [6:0] randomInputs();
    logic [6:0] v;
    v[6] = ($urandom_range(0, 5) == 0);
    v[5] = ($urandom_range(0, 7) == 0);
    v[4] = ($urandom_range(0, 3) != 0);
    v[3] = ($urandom_range(0, 2) == 0);
    v[2] = ($urandom_range(0, 1) == 0);
    v[1] = ($urandom_range(0, 5) == 0);
    v[0] = ($urandom_range(0, 39) == 0);
    return v;
  endfunction

  initial begin
    vecs[0] = '{7'b0010000, 10'b1_1111_0000_0};  // all advance
    vecs[1] = '{7'b0000000, 10'b0_1111_1000_0};  // ifetch miss
    vecs[2] = '{7'b1010000, 10'b0_0111_0100_0};  // load-use
    vecs[3] = '{7'b0000010, 10'b1_1111_1100_0};  // branch over ifetch miss
    vecs[4] = '{7'b0110010, 10'b0_0011_0010_0};  // hazard_ex beats branch
    vecs[5] = '{7'b1111011, 10'b0_0000_0000_0};  // mem stall beats all
    vecs[6] = '{7'b0011101, 10'b0_1111_1110_0};  // halt with dhit
    vecs[7] = '{7'b0110001, 10'b0_1111_1110_0};  // halt beats hazard_ex
    vecs[8] = '{7'b1010010, 10'b1_1111_1100_0};  // branch beats hazard_dec
    vecs[9] = '{7'b1110000, 10'b0_0011_0010_0};  // hazard_ex beats hazard_dec

    driveInputs(1'b1, 7'b0);
    @(posedge CLK);
    #1;

    // Reset held two cycles, then release with ihit.
    applyStimulus(1'b1, 7'b0, 1'b1, 10'b0_0000_1111_0);
    applyStimulus(1'b1, 7'b0, 1'b1, 10'b0_0000_1111_0);
    applyStimulus(1'b0, 7'b0010000, 1'b1, 10'b1_1111_0000_0);
    checkOutput("reset_cycle_cnt", 64'(bus_big.cycle_cnt), 64'd1);

    // Single-cycle priority vectors, each from a fresh reset.
    foreach (vecs[i]) begin
      step(1'b1, 7'b0);
      applyStimulus(1'b0, vecs[i].in, 1'b1, vecs[i].exp);
    end

    // Load-use stall.
    step(1'b1, 7'b0);
    applyStimulus(1'b0, 7'b1010000, 1'b1, 10'b0_0111_0100_0);
    checkOutput("loaduse_stall_cnt", 64'(bus_big.stall_cnt), 64'd1);

    // Dcache miss for three cycles, then hit.
    step(1'b1, 7'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 7'b0011000, 1'b1, 10'b0_0000_0000_0);
    applyStimulus(1'b0, 7'b0011100, 1'b1, 10'b1_1111_0000_0);
    checkOutput("dmiss_stall_cnt", 64'(bus_big.stall_cnt), 64'd3);

    // Branch shadowed by hazard_ex, then taken alone.
    step(1'b1, 7'b0);
    applyStimulus(1'b0, 7'b0110010, 1'b1, 10'b0_0011_0010_0);
    checkOutput("branch_hzd_flush_cnt", 64'(bus_big.flush_cnt), 64'd0);
    applyStimulus(1'b0, 7'b0010010, 1'b1, 10'b1_1111_1100_0);
    checkOutput("branch_flush_cnt", 64'(bus_big.flush_cnt), 64'd1);

    // Halt behind a pending memory op, then drain and stay halted.
    step(1'b1, 7'b0);
    applyStimulus(1'b0, 7'b0011001, 1'b1, 10'b0_0000_0000_0);
    applyStimulus(1'b0, 7'b0011101, 1'b1, 10'b0_1111_1110_0);
    applyStimulus(1'b0, randomInputs(), 1'b1, 10'b0_0000_0001_0);
    checkOutput("halt_rise", 64'(bus_big.halt), 64'd1);
    checkOutput("halt_cycle_cnt", 64'(bus_big.cycle_cnt), 64'd3);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, randomInputs(), 1'b1, 10'b0_0000_0000_1);
    checkOutput("halted_cycle_cnt", 64'(bus_big.cycle_cnt), 64'd3);
    step(1'b1, randomInputs());
    checkOutput("halt_cleared", 64'(bus_big.halt), 64'd0);
    checkOutput("halt_reset_cnt", 64'(bus_big.cycle_cnt), 64'd0);

    // Saturation of the 4-bit counters.
    step(1'b1, 7'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 7'b0000000);
    checkOutput("sat_cycle_w4", 64'(bus_small.cycle_cnt), 64'd15);
    checkOutput("sat_stall_w4", 64'(bus_small.stall_cnt), 64'd15);
    checkOutput("sat_cycle_w32", 64'(bus_big.cycle_cnt), 64'd20);
    checkOutput("sat_stall_w32", 64'(bus_big.stall_cnt), 64'd20);

    // Random traffic with occasional resets against the model.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) == 0), randomInputs());

    $display("[TB] stimulus complete");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Pipeline stall/flush controller for the five-stage pipelined datapath; it sits directly downstream of the hazard unit. Each cycle it combines the hazard unit's `hazard_dec`/`hazard_ex` flags with cache handshakes (`ihit`, `dhit`), taken-branch resolution in EX, and halt detection in MEM. From these it drives enable/flush for the PC and the four pipeline latches. It owns the halt drain sequence and keeps saturating performance counters.

## Interface
- `CNT_W`, 32, width of each performance counter
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `hazard_dec`  in  1  RAW hazard on the instruction in decode (from hazard unit)
- `hazard_ex`  in  1  RAW hazard on the instruction in execute (from hazard unit)
- `ihit`  in  1  instruction fetch complete this cycle
- `dmem_req_mem`  in  1  MEM-stage instruction is a load/store (dREN|dWEN)
- `dhit`  in  1  data access complete this cycle
- `branch_ex`  in  1  taken branch/jump resolved in EX this cycle
- `halt_mem`  in  1  halt instruction present in MEM
- `pc_en`  out  1  PC load enable
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  latch load enables
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load NOP into latch; flush overrides en
- `halt`  out  1  processor halted (sticky)
- `cycle_cnt`, `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters

## Operation
- States: RUN, DWAIT, DRAIN, HALTED; reset -> RUN.
- While `RST`=1: all en=0, all flush=1, pc_en=0, halt=0; counters cleared on the edge.
- Define `mstall = dmem_req_mem & ~dhit`.
- RUN/DWAIT output priority (first match wins; unlisted en=1, flush=0, pc_en=1):
  - `mstall`: pc_en=0, all latch en=0 (full freeze). Next state DWAIT.
  - `halt_mem`: pc_en=0, ifid/idex/exmem flush=1, memwb_en=1. Next state DRAIN.
  - `hazard_ex`: pc_en=0, ifid_en=0, idex_en=0, exmem_flush=1.
  - `branch_ex`: pc_en=1 (target), ifid_flush=1, idex_flush=1.
  - `hazard_dec`: pc_en=0, ifid_en=0, idex_flush=1.
  - `~ihit`: pc_en=0, ifid_flush=1.
  - else all advance.
- DWAIT behaves as RUN. It returns to RUN on the first cycle `mstall`=0; that cycle's outputs come from the priority list above.
- DRAIN (exactly 1 cycle): pc_en=0, all latch en=0, memwb_flush=1. Next state HALTED.
- HALTED: all en=0, flush=0, pc_en=0, halt=1. Inputs are ignored; exit only via `RST`.
- Counters: saturating at all-ones, never wrap.
  - `cycle_cnt` increments every non-reset cycle while not HALTED.
  - `stall_cnt` increments when pc_en=0 in RUN/DWAIT.
  - `flush_cnt` increments on cycles where the `branch_ex` rule is selected.

## Timing
- Enable/flush outputs are combinational from current state plus inputs; latches sample them at the same rising edge.
- State and counters update on rising `CLK`; counter outputs are registered, with one-cycle latency after the qualifying cycle.
- `halt` rises the cycle after DRAIN, i.e. 2 cycles after the `halt_mem` edge that is not stalled.
- `branch_ex` concurrent with `hazard_ex` is ignored; the branch re-resolves once the hazard clears.
- `branch_ex` concurrent with `~ihit` still loads the PC. The flush covers the stale fetch.
- `halt_mem` under `mstall` waits; halt is taken only once the memory op completes.
- `RST` in any state, including DRAIN/HALTED, returns to RUN on the next edge with counters zeroed.

## Test plan
- Reset: hold `RST` 2 cycles, all inputs 0 -> all en=0, all flush=1; after release with `ihit`=1 all en=1, counters 0 then `cycle_cnt`=1 next cycle.
- Load-use: `hazard_dec`=1 for 1 cycle, `ihit`=1 -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; `stall_cnt`=1.
- Dcache miss: `dmem_req_mem`=1, `dhit`=0 for 3 cycles then 1 -> 3 full-freeze cycles in DWAIT, return to RUN, `stall_cnt`=3.
- Branch vs hazard: `branch_ex`=1 with `hazard_ex`=1 -> exmem_flush=1, no ifid/idex flush, `flush_cnt` unchanged; next cycle `branch_ex` alone -> ifid/idex flush, `flush_cnt`=1.
- Halt: `halt_mem`=1 -> DRAIN next cycle (memwb_flush=1), `halt`=1 the following cycle and stays 1 with random inputs; `cycle_cnt` frozen; `RST` clears.
- Saturation: with CNT_W=4, run 20 cycles with `~ihit` -> `cycle_cnt`=`stall_cnt`=15.
